// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/trap sequencing for the 5-stage rv64IM pipeline registers.
// Optional perf counters are compiled in when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int TRAP_DRAIN  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_branch_taken,
    input  logic       ex_load,
    input  logic       ex_wen,
    input  logic [4:0] ex_rd,
    input  logic       ex_mdu_start,
    input  logic       ex_mdu_done,
    input  logic       wb_exception,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       trap_redirect,
    output logic       mdu_timeout
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [63:0] perf_stall_cycles,
    output logic [63:0] perf_flush_events,
    output logic [31:0] perf_trap_count
`endif
);
    localparam int MW = $clog2(MDU_TIMEOUT) + 1;
    localparam int TW = $clog2(TRAP_DRAIN) + 1;

    typedef enum logic [1:0] {RUN, MDU_BUSY, TRAP} state_t;

    state_t        state, state_nx;
    logic [MW-1:0] mdu_cnt, mdu_cnt_nx;
    logic [TW-1:0] trap_cnt, trap_cnt_nx;
    logic          to_q, to_nx;
    logic          load_use, mdu_last;

    assign load_use = ex_load & ex_wen & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign mdu_last = mdu_cnt == MW'(MDU_TIMEOUT - 1);
    assign mdu_timeout = to_q & ~reset;

    // Next-state and stall/flush decode; trap beats load-use beats branch beats MDU stall.
    always_comb begin
        state_nx      = state;
        mdu_cnt_nx    = mdu_cnt;
        trap_cnt_nx   = trap_cnt;
        to_nx         = to_q;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        trap_redirect = 1'b0;
        case (state)
            RUN: begin
                if (wb_exception) begin
                    {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
                    state_nx    = TRAP;
                    trap_cnt_nx = TW'(TRAP_DRAIN - 1);
                end else begin
                    if (load_use)
                        {pc_stall, if_id_stall, id_ex_flush} = 3'b111;
                    else if (id_branch_taken)
                        if_id_flush = 1'b1;
                    else if (ex_mdu_start & ~ex_mdu_done)
                        {pc_stall, if_id_stall, id_ex_stall, ex_mem_flush} = 4'b1111;
                    if (ex_mdu_start & ~ex_mdu_done) begin
                        state_nx   = MDU_BUSY;
                        mdu_cnt_nx = '0;
                    end
                end
            end
            MDU_BUSY: begin
                if (wb_exception) begin
                    {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
                    state_nx    = TRAP;
                    trap_cnt_nx = TW'(TRAP_DRAIN - 1);
                end else if (ex_mdu_done) begin
                    state_nx = RUN;
                end else if (mdu_last) begin
                    state_nx = RUN;
                    to_nx    = 1'b1;
                end else begin
                    {pc_stall, if_id_stall, id_ex_stall, ex_mem_flush} = 4'b1111;
                    mdu_cnt_nx = mdu_cnt + 1'b1;
                end
            end
            TRAP: begin
                {pc_stall, if_id_flush, id_ex_flush, ex_mem_flush} = 4'b1111;
                trap_redirect = trap_cnt == TW'(TRAP_DRAIN - 1);
                trap_cnt_nx   = trap_cnt - 1'b1;
                if (trap_cnt == '0) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
        if (reset) begin
            {pc_stall, if_id_stall, if_id_flush, id_ex_stall} = 4'b0000;
            {id_ex_flush, ex_mem_flush, trap_redirect} = 3'b000;
        end
    end

    // State, counters and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            mdu_cnt  <= '0;
            trap_cnt <= '0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            mdu_cnt  <= mdu_cnt_nx;
            trap_cnt <= trap_cnt_nx;
            to_q     <= to_nx;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    // Free-running event counters that wrap at full width.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
            perf_trap_count   <= '0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + 64'(pc_stall);
            perf_flush_events <= perf_flush_events + 64'(if_id_flush | id_ex_flush | ex_mem_flush);
            perf_trap_count   <= perf_trap_count + 32'(trap_redirect);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a cycle model.
module tb_pipe_hazard_ctrl;
    localparam int MT = 8;
    localparam int TD = 2;
    localparam int M_RUN = 0, M_BUSY = 1, M_TRAP = 2;

    logic clock = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, id_branch_taken, ex_load, ex_wen;
    logic ex_mdu_start, ex_mdu_done, wb_exception;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush;
    logic trap_redirect, mdu_timeout;
`ifdef PIPE_HAZARD_PERF_EN
    logic [63:0] perf_stall_cycles, perf_flush_events;
    logic [31:0] perf_trap_count;
`endif

    pipe_hazard_ctrl #(.MDU_TIMEOUT(MT), .TRAP_DRAIN(TD)) dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_branch_taken(id_branch_taken), .ex_load(ex_load), .ex_wen(ex_wen), .ex_rd(ex_rd),
        .ex_mdu_start(ex_mdu_start), .ex_mdu_done(ex_mdu_done), .wb_exception(wb_exception),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .trap_redirect(trap_redirect), .mdu_timeout(mdu_timeout)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flush_events(perf_flush_events),
        .perf_trap_count(perf_trap_count)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference state: which phase the pipeline is in and how long it has been there.
    int mode = M_RUN;
    int busy_n = 0;
    int trap_left = 0;
    bit m_to = 1'b0;
    longint p_st = 0, p_fl = 0, p_tr = 0;

    wire [7:0] outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                       id_ex_flush, ex_mem_flush, trap_redirect, mdu_timeout};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output vector bits: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, trap_redirect, mdu_timeout
    function automatic logic [7:0] model_out();
        logic [7:0] r;
        bit lu;
        lu = ex_load && ex_wen && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (reset) return 8'h00;
        r = {7'b0, m_to};
        if (mode == M_RUN) begin
            if (wb_exception) r |= 8'h2C;
            else if (lu) r |= 8'hC8;
            else if (id_branch_taken) r |= 8'h20;
            else if (ex_mdu_start && !ex_mdu_done) r |= 8'hD4;
        end else if (mode == M_BUSY) begin
            if (wb_exception) r |= 8'h2C;
            else if (!ex_mdu_done && busy_n < MT - 1) r |= 8'hD4;
        end else begin
            r |= 8'hAC | ((trap_left == TD) ? 8'h02 : 8'h00);
        end
        return r;
    endfunction

    task automatic model_step(input logic [7:0] e);
        if (reset) begin
            mode = M_RUN; m_to = 1'b0; p_st = 0; p_fl = 0; p_tr = 0;
            return;
        end
        p_st += e[7];
        p_fl += (e[5] | e[3] | e[2]);
        p_tr += e[1];
        case (mode)
            M_RUN: begin
                if (wb_exception) begin mode = M_TRAP; trap_left = TD; end
                else if (ex_mdu_start && !ex_mdu_done) begin mode = M_BUSY; busy_n = 0; end
            end
            M_BUSY: begin
                if (wb_exception) begin mode = M_TRAP; trap_left = TD; end
                else if (ex_mdu_done) mode = M_RUN;
                else if (busy_n == MT - 1) begin mode = M_RUN; m_to = 1'b1; end
                else busy_n++;
            end
            default: begin
                trap_left--;
                if (trap_left == 0) mode = M_RUN;
            end
        endcase
    endtask

    // One clock: check outputs mid-cycle (optionally against a fixed value too), then advance.
    task automatic cyc(input string tag, input bit use_c = 1'b0, input logic [7:0] c = 8'h00);
        logic [7:0] e;
        #2;
        e = model_out();
        check(tag, outs, e);
        if (use_c) check({tag, "_fixed"}, outs, c);
        @(posedge clock);
        model_step(e);
        #1;
`ifdef PIPE_HAZARD_PERF_EN
        check("perf_stall", perf_stall_cycles, p_st);
        check("perf_flush", perf_flush_events, p_fl);
        check("perf_trap", perf_trap_count, p_tr);
`endif
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_use_rs1, id_use_rs2, id_branch_taken, ex_load, ex_wen} = '0;
        {ex_mdu_start, ex_mdu_done, wb_exception} = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc("reset", 1'b1, 8'h00);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cyc("reset", 1'b1, 8'h00);
        cyc("reset", 1'b1, 8'h00);
        reset = 1'b0;
        cyc("idle", 1'b1, 8'h00);

        ex_load = 1; ex_wen = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        cyc("load_use", 1'b1, 8'hC8);
        idle();
        cyc("load_use_once", 1'b1, 8'h00);
        ex_load = 1; ex_wen = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        cyc("load_use_x0", 1'b1, 8'h00);
        ex_load = 1; ex_wen = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1; id_use_rs1 = 0;
        cyc("load_use_rs2", 1'b1, 8'hC8);
        idle();
        id_branch_taken = 1;
        cyc("branch", 1'b1, 8'h20);
        ex_load = 1; ex_wen = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        cyc("branch_lu", 1'b1, 8'hC8);

        idle();
        ex_mdu_start = 1;
        for (int i = 0; i < 5; i++) cyc("mdu_hold", 1'b1, 8'hD4);
        ex_mdu_done = 1;
        cyc("mdu_done", 1'b1, 8'h00);
        idle();
        cyc("mdu_after", 1'b1, 8'h00);
        ex_mdu_start = 1; ex_mdu_done = 1;
        cyc("mdu_start_done", 1'b1, 8'h00);

        idle();
        ex_mdu_start = 1;
        for (int i = 0; i < MT; i++) cyc("mdu_to_hold", 1'b1, 8'hD4);
        cyc("mdu_to_release", 1'b1, 8'h00);
        idle();
        cyc("mdu_to_sticky", 1'b1, 8'h01);
        cyc("mdu_to_sticky2", 1'b1, 8'h01);
        do_reset();
        cyc("to_cleared", 1'b1, 8'h00);

        wb_exception = 1;
        cyc("trap_entry", 1'b1, 8'h2C);
        cyc("trap_first", 1'b1, 8'hAE);
        idle();
        cyc("trap_second", 1'b1, 8'hAC);
        cyc("trap_done", 1'b1, 8'h00);

        ex_mdu_start = 1;
        cyc("mdu_pre_trap", 1'b1, 8'hD4);
        cyc("mdu_pre_trap2", 1'b1, 8'hD4);
        wb_exception = 1;
        cyc("mdu_trap_entry", 1'b1, 8'h2C);
        idle();
        cyc("mdu_trap_first", 1'b1, 8'hAE);

        do_reset();
        wb_exception = 1;
        cyc("rst_trap_entry", 1'b1, 8'h2C);
        idle();
        cyc("rst_trap_first", 1'b1, 8'hAE);
        reset = 1'b1;
        cyc("rst_mid_trap", 1'b1, 8'h00);
        reset = 1'b0;
        cyc("rst_after_trap", 1'b1, 8'h00);
        cyc("rst_after_trap2", 1'b1, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom);
            id_use_rs2 = 1'($urandom);
            id_branch_taken = ($urandom_range(0, 3) == 0);
            ex_load = 1'($urandom);
            ex_wen = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) ex_mdu_start = ~ex_mdu_start;
            ex_mdu_done = ($urandom_range(0, 11) == 0);
            wb_exception = ($urandom_range(0, 29) == 0);
            cyc("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
